mem_arbiter: RTL and testbench

Request arbiter and sequencer sitting between the instruction fetcher, the load/store unit (LSU) and the byte-serial memory controller. It holds one pending request per requester and picks one by LSU-first priority with a fetch starvation guard. It issues that request over a single valid/ready/done port and routes the completion back to its owner. It also applies pipeline-flush kill rules, so the memory controller never sees drop semantics.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/arb_slot.sv | 29 ++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam logic       READ_FLAG  = 1'b0;
  localparam logic       WRITE_FLAG = 1'b1;
  localparam logic [2:0] SIZE_WORD  = 3'd4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } ls_req_t;

endpackage

// File: rtl/arb_slot.sv
// One-entry request holding register; clear has priority over accept.
module arb_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         accept,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (en) begin
      if (clear) begin
        valid <= 1'b0;
      end else if (accept) begin
        valid <= 1'b1;
        dout  <= din;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter in front of the byte-serial memory controller.
// state | meaning
// IDLE  | no op in flight; issue the winning slot if any is live
// ISSUE | mem_valid_out held until the controller accepts
// WAIT  | accepted; waiting for mem_done_in to route the completion
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ready_out,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        ls_req_in,
  input  logic        ls_we_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_wdata_in,
  input  logic [2:0]  ls_size_in,
  output logic        ls_ready_out,
  output logic        ls_done_out,
  output logic [31:0] ls_rdata_out,
  output logic        mem_valid_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [2:0]  mem_size_out,
  input  logic        mem_ready_in,
  input  logic        mem_done_in,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t      state, next_state;
  owner_t      owner;
  logic        killed;
  logic [2:0]  starve_cnt;
  logic        if_valid, ls_valid;
  logic [31:0] if_addr_q;
  ls_req_t     ls_din, ls_q;
  logic        if_live, ls_live, fetch_wins, issue, complete;
  logic        if_accept, ls_accept, if_clear, ls_clear;
  logic        killable, kill_now;

  assign if_ready_out = !if_valid;
  assign ls_ready_out = !ls_valid;
  assign ls_din       = '{ls_we_in, ls_addr_in, ls_wdata_in, ls_size_in};

  // A flush removes entries before arbitration, so a flushed slot never issues.
  assign if_live    = if_valid && !flush_in;
  assign ls_live    = ls_valid && !(flush_in && ls_q.we == READ_FLAG);
  assign fetch_wins = if_live && (!ls_live || starve_cnt == STARVE_MAX);
  assign issue      = (state == IDLE) && (if_live || ls_live);

  assign if_accept = if_req_in && !if_valid && !flush_in;
  assign ls_accept = ls_req_in && !ls_valid;
  assign if_clear  = flush_in || (issue && fetch_wins);
  assign ls_clear  = (ls_valid && !ls_live) || (issue && !fetch_wins);

  assign killable = (owner == OWN_IF) || (mem_we_out != WRITE_FLAG);
  assign kill_now = killed || (flush_in && killable);

  arb_slot #(.W(32)) u_if_slot (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .en     (rdy_in),
    .accept (if_accept),
    .clear  (if_clear),
    .din    (if_addr_in),
    .valid  (if_valid),
    .dout   (if_addr_q)
  );

  arb_slot #(.W($bits(ls_req_t))) u_ls_slot (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .en     (rdy_in),
    .accept (ls_accept),
    .clear  (ls_clear),
    .din    (ls_din),
    .valid  (ls_valid),
    .dout   (ls_q)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) next_state = ISSUE;
      end
      ISSUE: begin
        if (mem_ready_in) begin
          if (mem_done_in) begin
            complete   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_done_in) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      owner         <= OWN_IF;
      killed        <= 1'b0;
      starve_cnt    <= '0;
      mem_valid_out <= 1'b0;
      mem_we_out    <= READ_FLAG;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_size_out  <= '0;
      if_done_out   <= 1'b0;
      if_inst_out   <= '0;
      ls_done_out   <= 1'b0;
      ls_rdata_out  <= '0;
    end else if (rdy_in) begin
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;

      if (issue) begin
        mem_valid_out <= 1'b1;
        if (fetch_wins) begin
          owner         <= OWN_IF;
          mem_we_out    <= READ_FLAG;
          mem_addr_out  <= if_addr_q;
          mem_wdata_out <= '0;
          mem_size_out  <= SIZE_WORD;
          starve_cnt    <= '0;
        end else begin
          owner         <= OWN_LS;
          mem_we_out    <= ls_q.we;
          mem_addr_out  <= ls_q.addr;
          mem_wdata_out <= ls_q.wdata;
          mem_size_out  <= ls_q.size;
          if (if_live && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
        end
      end else if (state == ISSUE && mem_ready_in) begin
        mem_valid_out <= 1'b0;
      end

      if (complete && !kill_now) begin
        if (owner == OWN_IF) begin
          if_done_out <= 1'b1;
          if_inst_out <= mem_rdata_in;
        end else begin
          ls_done_out  <= 1'b1;
          ls_rdata_out <= mem_rdata_in;
        end
      end

      if (complete) begin
        killed <= 1'b0;
      end else if (flush_in && state != IDLE && killable) begin
        killed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in;
  logic        if_req_in, if_ready_out, if_done_out;
  logic [31:0] if_addr_in, if_inst_out;
  logic        ls_req_in, ls_we_in, ls_ready_out, ls_done_out;
  logic [31:0] ls_addr_in, ls_wdata_in, ls_rdata_out;
  logic [2:0]  ls_size_in;
  logic        mem_valid_out, mem_we_out, mem_ready_in, mem_done_in;
  logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
  logic [2:0]  mem_size_out;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_ready_out(if_ready_out),
    .if_done_out(if_done_out), .if_inst_out(if_inst_out),
    .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_addr_in(ls_addr_in),
    .ls_wdata_in(ls_wdata_in), .ls_size_in(ls_size_in), .ls_ready_out(ls_ready_out),
    .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
    .mem_valid_out(mem_valid_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_size_out(mem_size_out),
    .mem_ready_in(mem_ready_in), .mem_done_in(mem_done_in), .mem_rdata_in(mem_rdata_in)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // next-cycle stimulus, and a copy of what was driven into the last edge
  bit          n_if_req, n_ls_req, n_ls_we, n_flush, n_rdy, n_mready, n_mdone;
  logic [31:0] n_if_addr, n_ls_addr, n_ls_wdata, n_rdata;
  logic [2:0]  n_ls_size;
  bit          d_if_req, d_ls_req, d_ls_we, d_flush, d_rdy, d_mready, d_mdone;
  logic [31:0] d_if_addr, d_ls_addr, d_ls_wdata, d_rdata;
  logic [2:0]  d_ls_size;
  bit          r_if_ready, r_ls_ready;

  // reference model: pending requests, the op in flight, expected outputs
  bit          m_if_pend, m_ls_pend, m_ls_we;
  logic [31:0] m_if_addr, m_ls_addr, m_ls_wdata;
  logic [2:0]  m_ls_size;
  int          m_starve;
  bit          m_busy, m_wait, m_own_if, m_own_store, m_killed;
  bit          e_mem_valid, e_mem_we, e_if_done, e_ls_done, e_wdata_known;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_inst, e_ls_rdata;
  logic [2:0]  e_mem_size;

  int last_wait;
  int refill_addr = 32'h0000_2100;

  task automatic clear_next();
    n_if_req = 0; n_ls_req = 0; n_ls_we = 0; n_flush = 0; n_rdy = 1;
    n_mready = 0; n_mdone = 0; n_if_addr = '0; n_ls_addr = '0;
    n_ls_wdata = '0; n_rdata = '0; n_ls_size = 3'd4;
  endtask

  task automatic model_reset();
    m_if_pend = 0; m_ls_pend = 0; m_ls_we = 0; m_starve = 0;
    m_busy = 0; m_wait = 0; m_own_if = 0; m_own_store = 0; m_killed = 0;
    e_mem_valid = 0; e_mem_we = 0; e_if_done = 0; e_ls_done = 0; e_wdata_known = 1;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_inst = '0; e_ls_rdata = '0; e_mem_size = '0;
  endtask

  task automatic model_update();
    bit was_busy, fetch_win;
    if (!d_rdy) return;
    e_if_done = 0;
    e_ls_done = 0;
    was_busy  = m_busy;
    if (d_flush) begin
      m_if_pend = 0;
      if (m_ls_pend && !m_ls_we) m_ls_pend = 0;
      if (m_busy && !m_own_store) m_killed = 1;
    end
    if (was_busy) begin
      if (!m_wait && d_mready) begin
        m_wait = 1;
        e_mem_valid = 0;
      end
      if (m_wait && d_mdone) begin
        if (!m_killed) begin
          if (m_own_if) begin e_if_done = 1; e_if_inst = d_rdata; end
          else begin e_ls_done = 1; e_ls_rdata = d_rdata; end
        end
        m_busy = 0;
      end
    end else if (m_if_pend || m_ls_pend) begin
      fetch_win = m_if_pend && (!m_ls_pend || m_starve == LIMIT);
      m_busy = 1; m_wait = 0; m_killed = 0; e_mem_valid = 1;
      if (fetch_win) begin
        m_if_pend = 0; m_starve = 0; m_own_if = 1; m_own_store = 0;
        e_mem_we = 0; e_mem_addr = m_if_addr; e_mem_size = 3'd4; e_wdata_known = 0;
      end else begin
        if (m_if_pend) m_starve++;
        m_ls_pend = 0; m_own_if = 0; m_own_store = m_ls_we;
        e_mem_we = m_ls_we; e_mem_addr = m_ls_addr; e_mem_size = m_ls_size;
        e_mem_wdata = m_ls_wdata; e_wdata_known = 1;
      end
    end
    if (d_if_req && r_if_ready && !d_flush) begin
      m_if_pend = 1; m_if_addr = d_if_addr;
    end
    if (d_ls_req && r_ls_ready) begin
      m_ls_pend = 1; m_ls_we = d_ls_we; m_ls_addr = d_ls_addr;
      m_ls_wdata = d_ls_wdata; m_ls_size = d_ls_size;
    end
  endtask

  task automatic check_outputs();
    chk("if_ready", if_ready_out, !m_if_pend);
    chk("ls_ready", ls_ready_out, !m_ls_pend);
    chk("mem_valid", mem_valid_out, e_mem_valid);
    chk("mem_we", mem_we_out, e_mem_we);
    chk("mem_addr", mem_addr_out, e_mem_addr);
    chk("mem_size", mem_size_out, e_mem_size);
    if (e_wdata_known) chk("mem_wdata", mem_wdata_out, e_mem_wdata);
    chk("if_done", if_done_out, e_if_done);
    chk("if_inst", if_inst_out, e_if_inst);
    chk("ls_done", ls_done_out, e_ls_done);
    chk("ls_rdata", ls_rdata_out, e_ls_rdata);
  endtask

  task automatic step();
    if_req_in = n_if_req; if_addr_in = n_if_addr;
    ls_req_in = n_ls_req; ls_we_in = n_ls_we; ls_addr_in = n_ls_addr;
    ls_wdata_in = n_ls_wdata; ls_size_in = n_ls_size;
    flush_in = n_flush; rdy_in = n_rdy;
    mem_ready_in = n_mready; mem_done_in = n_mdone; mem_rdata_in = n_rdata;
    d_if_req = n_if_req; d_if_addr = n_if_addr; d_ls_req = n_ls_req; d_ls_we = n_ls_we;
    d_ls_addr = n_ls_addr; d_ls_wdata = n_ls_wdata; d_ls_size = n_ls_size;
    d_flush = n_flush; d_rdy = n_rdy; d_mready = n_mready; d_mdone = n_mdone; d_rdata = n_rdata;
    r_if_ready = !m_if_pend;
    r_ls_ready = !m_ls_pend;
    clear_next();
    @(negedge clk_in);
    model_update();
    check_outputs();
  endtask

  task automatic wait_issue();
    last_wait = 0;
    for (int i = 0; i < 30 && !mem_valid_out; i++) begin
      step();
      last_wait++;
    end
    chk("issue_timeout", mem_valid_out, 1);
  endtask

  task automatic complete_op(input logic [31:0] rdata, input bit refill);
    n_mready = 1;
    if (refill) begin
      n_ls_req = 1; n_ls_we = 0; n_ls_addr = refill_addr; n_ls_size = 3'd4;
      refill_addr += 4;
    end
    step();
    n_mdone = 1;
    n_rdata = rdata;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (m_if_pend || m_ls_pend); i++) begin
      wait_issue();
      complete_op($urandom, 0);
    end
  endtask

  task automatic load_req(input logic [31:0] addr);
    n_ls_req = 1; n_ls_we = 0; n_ls_addr = addr; n_ls_size = 3'd4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fetch_at;
    rst_n_in = 0; rdy_in = 1; flush_in = 0; if_req_in = 0; if_addr_in = '0;
    ls_req_in = 0; ls_we_in = 0; ls_addr_in = '0; ls_wdata_in = '0; ls_size_in = '0;
    mem_ready_in = 0; mem_done_in = 0; mem_rdata_in = '0;
    model_reset();
    clear_next();
    repeat (2) @(negedge clk_in);
    check_outputs();
    rst_n_in = 1;

    // single fetch, minimum latency
    n_if_req = 1; n_if_addr = 32'h100;
    step();
    wait_issue();
    chk("fetch_latency", last_wait, 1);
    chk("fetch_addr", mem_addr_out, 32'h100);
    chk("fetch_size", mem_size_out, 3'd4);
    complete_op(32'h00A0_0093, 0);
    chk("fetch_done", if_done_out, 1);
    chk("fetch_inst", if_inst_out, 32'h00A0_0093);
    step();
    chk("fetch_done_pulse", if_done_out, 0);

    // contention: load beats fetch
    n_if_req = 1; n_if_addr = 32'h400;
    load_req(32'h2000);
    step();
    wait_issue();
    chk("cont_first", mem_addr_out, 32'h2000);
    complete_op(32'h1111_2222, 0);
    wait_issue();
    chk("cont_second", mem_addr_out, 32'h400);
    complete_op(32'h3333_4444, 0);

    // starvation guard
    n_if_req = 1; n_if_addr = 32'h500;
    load_req(32'h2040);
    step();
    fetch_at = 0;
    for (int k = 1; k <= 5; k++) begin
      wait_issue();
      if (fetch_at == 0 && mem_addr_out == 32'h500 && !mem_we_out) fetch_at = k;
      complete_op($urandom, k < 5);
    end
    chk("starve_position", fetch_at, 5);
    drain();

    // flush during WAIT on a load
    load_req(32'h3000);
    step();
    wait_issue();
    n_mready = 1;
    step();
    n_flush = 1;
    step();
    n_mdone = 1; n_rdata = 32'h5555_AAAA;
    step();
    chk("flushed_load_done", ls_done_out, 0);
    load_req(32'h3008);
    step();
    wait_issue();
    complete_op(32'h0BAD_F00D, 0);
    chk("post_kill_load_done", ls_done_out, 1);

    // flush during WAIT on a store
    n_ls_req = 1; n_ls_we = 1; n_ls_addr = 32'h3004; n_ls_wdata = 32'hDEAD_BEEF; n_ls_size = 3'd4;
    step();
    wait_issue();
    chk("store_wdata", mem_wdata_out, 32'hDEAD_BEEF);
    n_mready = 1;
    step();
    n_flush = 1;
    step();
    n_mdone = 1;
    step();
    chk("flushed_store_done", ls_done_out, 1);

    // pending load flushed while a store is in flight
    n_ls_req = 1; n_ls_we = 1; n_ls_addr = 32'h3010; n_ls_wdata = 32'h1234_5678; n_ls_size = 3'd2;
    step();
    wait_issue();
    n_mready = 1;
    load_req(32'h3020);
    step();
    chk("ls_slot_held", ls_ready_out, 0);
    n_flush = 1;
    step();
    chk("ls_slot_flushed", ls_ready_out, 1);
    n_mdone = 1;
    step();
    chk("store_in_flight_done", ls_done_out, 1);
    repeat (3) step();

    // stall mid-ISSUE, then reset during WAIT
    n_if_req = 1; n_if_addr = 32'h600;
    step();
    wait_issue();
    for (int i = 0; i < 3; i++) begin
      n_rdy = 0; n_mready = 1; n_if_req = 1; n_if_addr = 32'h700;
      load_req(32'h3030);
      step();
    end
    chk("stall_valid", mem_valid_out, 1);
    chk("stall_addr", mem_addr_out, 32'h600);
    n_mready = 1;
    step();
    #2 rst_n_in = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_in);
    rst_n_in = 1;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      n_rdy      = ($urandom_range(0, 9) != 0);
      n_flush    = n_rdy && ($urandom_range(0, 19) == 0);
      n_if_req   = ($urandom_range(0, 2) == 0);
      n_if_addr  = $urandom & 32'hFFFF_FFFC;
      n_ls_req   = !n_flush && ($urandom_range(0, 1) == 1);
      n_ls_we    = ($urandom_range(0, 1) == 1);
      n_ls_addr  = $urandom;
      n_ls_wdata = $urandom;
      case ($urandom_range(0, 2))
        0:       n_ls_size = 3'd1;
        1:       n_ls_size = 3'd2;
        default: n_ls_size = 3'd4;
      endcase
      n_mready = n_rdy && m_busy && !m_wait && ($urandom_range(0, 1) == 1);
      n_mdone  = n_rdy && m_busy && (m_wait || n_mready) && ($urandom_range(0, 2) == 0);
      n_rdata  = $urandom;
      step();
    end
    drain();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
